vec_reduce_acc: RTL and testbench

VEC_REDUCE_ACC -- requirements
Module: vec_reduce_acc

---
 rtl/vec_reduce_acc.sv | 161 ++++++++++++++++
 tb/tb_vec_reduce_acc.sv | 470 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_reduce_acc.sv
// -----------------------------------------------------------------------------
// vec_reduce_acc
//   Reduces 16-lane signed 16-bit ALU vector results to one value per beat and
//   accumulates beats into FIR output samples. A beat tagged in_last closes the
//   sample: the accumulated value is presented on out_data together with a
//   sticky signed-overflow flag. The accumulator wraps in two's complement.
//
//   Pipeline: S1 pairwise lane sums (8 x 17b) -> S2 quad sums (2 x 19b)
//             -> S3 accumulate / output register.
//   The entire pipeline advances on en = ~(out_valid & ~out_ready); an unread
//   output sample stalls every stage, and in_ready mirrors en.
//
// Ports
//   clk        single clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   upstream beat valid
//   in_ready   beat accepted this cycle when in_valid is also high
//   in_data    16 signed lanes, lane k = in_data[16k+15:16k]
//   in_last    beat is the final tap group of the current sample
//   out_valid  output sample valid
//   out_ready  downstream accepts the sample
//   out_data   signed output sample, ACC_W bits
//   out_ovf    signed overflow occurred while accumulating this sample
// -----------------------------------------------------------------------------
module vec_reduce_acc #(
  parameter int ACC_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [255:0]     in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             out_ovf
);

  // Two guard bits hold the exact sum of acc and two 19-bit terms, since each
  // term is at most 2^18 in magnitude and ACC_W >= 20.
  localparam int WIDE_W = ACC_W + 2;

  function automatic logic [16:0] sx17(input logic [15:0] v);
    return {v[15], v};
  endfunction

  function automatic logic [18:0] sx19(input logic [16:0] v);
    return {{2{v[16]}}, v};
  endfunction

  function automatic logic [WIDE_W-1:0] sx_wide(input logic [18:0] v);
    return {{(WIDE_W-19){v[18]}}, v};
  endfunction

  logic en;
  assign en       = ~(out_valid & ~out_ready);
  assign in_ready = en;

  // ---------------------------------------------------------------------------
  // S1: pairwise lane sums
  // ---------------------------------------------------------------------------
  logic        s1_valid;
  logic        s1_last;
  logic [16:0] s1_sum [8];

  // NOTE: non-blocking assignments on every clocked register so all stages
  // sample the previous cycle's values and the pipeline advances in lockstep.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
    end else if (en) begin
      s1_valid <= in_valid;
      s1_last  <= in_last;
    end
  end

  // NOTE: datapath registers carry no reset; only the valid/last qualifiers
  // and the architectural state are cleared, so stale data is never observed.
  always_ff @(posedge clk) begin
    if (en && in_valid) begin
      for (int j = 0; j < 8; j++) begin
        s1_sum[j] <= sx17(in_data[32*j +: 16]) + sx17(in_data[32*j+16 +: 16]);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // S2: two quad sums
  // ---------------------------------------------------------------------------
  logic        s2_valid;
  logic        s2_last;
  logic [18:0] s2_a;
  logic [18:0] s2_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
    end else if (en) begin
      s2_valid <= s1_valid;
      s2_last  <= s1_last;
    end
  end

  always_ff @(posedge clk) begin
    if (en && s1_valid) begin
      s2_a <= sx19(s1_sum[0]) + sx19(s1_sum[1]) + sx19(s1_sum[2]) + sx19(s1_sum[3]);
      s2_b <= sx19(s1_sum[4]) + sx19(s1_sum[5]) + sx19(s1_sum[6]) + sx19(s1_sum[7]);
    end
  end

  // ---------------------------------------------------------------------------
  // S3: accumulate, detect overflow, publish sample on last beat
  // ---------------------------------------------------------------------------
  logic [ACC_W-1:0]  acc;
  logic              ovf_sticky;
  logic [WIDE_W-1:0] wide_sum;
  logic [ACC_W-1:0]  acc_next;
  logic [2:0]        top_bits;
  logic              beat_ovf;

  // NOTE: every signal driven here gets a value on every path, so no latch is
  // inferred.
  always_comb begin
    wide_sum = {{2{acc[ACC_W-1]}}, acc} + sx_wide(s2_a) + sx_wide(s2_b);
    acc_next = wide_sum[ACC_W-1:0];
    top_bits = wide_sum[WIDE_W-1:ACC_W-1];
    // The exact sum fits ACC_W signed bits only when the guard bits replicate
    // the ACC_W sign bit.
    beat_ovf = (top_bits != 3'b000) && (top_bits != 3'b111);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc        <= '0;
      ovf_sticky <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_ovf    <= 1'b0;
    end else if (en) begin
      // en high means the current sample (if any) is being consumed; it is
      // replaced only if a new sample completes in the same cycle.
      out_valid <= 1'b0;
      if (s2_valid) begin
        if (s2_last) begin
          out_data   <= acc_next;
          out_ovf    <= ovf_sticky | beat_ovf;
          out_valid  <= 1'b1;
          acc        <= '0;
          ovf_sticky <= 1'b0;
        end else begin
          acc        <= acc_next;
          ovf_sticky <= ovf_sticky | beat_ovf;
        end
      end
    end
  end

endmodule

// File: tb/tb_vec_reduce_acc.sv
// -----------------------------------------------------------------------------
// tb_vec_reduce_acc
//   Drives two instances (ACC_W = 32 and ACC_W = 20) with identical stimulus.
//   A reference model sums the accepted lanes as integers, wraps to each width
//   and tracks overflow of the running sum; completed samples are queued and
//   compared against the samples actually handed downstream.
// -----------------------------------------------------------------------------
module tb_vec_reduce_acc;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [255:0] in_data;
  logic         in_last;
  logic         out_ready;

  logic         in_ready,   in_ready20;
  logic         out_valid,  out_valid20;
  logic [31:0]  out_data;
  logic [19:0]  out_data20;
  logic         out_ovf,    out_ovf20;

  vec_reduce_acc #(.ACC_W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_ovf(out_ovf)
  );

  vec_reduce_acc #(.ACC_W(20)) dut20 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready20),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid20),
    .out_ready(out_ready), .out_data(out_data20), .out_ovf(out_ovf20)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d32;
    logic        o32;
    logic [19:0] d20;
    logic        o20;
    logic        v20;
  } sample_t;

  sample_t exp_q[$];
  sample_t got_q[$];
  int      checks = 0;
  int      fails  = 0;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  longint  m_acc32 = 0, m_acc20 = 0;
  bit      m_ovf32 = 0, m_ovf20 = 0;
  longint  m_beat;
  sample_t m_s;

  function automatic longint wrap(input longint v, input int w);
    longint m = longint'(1) <<< w;
    longint r = v & (m - 1);
    if (r >= m / 2) r = r - m;
    return r;
  endfunction

  function automatic void acc_step(inout longint acc, inout bit ovf,
                                   input longint b, input int w);
    longint t   = acc + b;
    longint lim = longint'(1) <<< (w - 1);
    if (t >= lim || t < -lim) ovf = 1'b1;
    acc = wrap(t, w);
  endfunction

  function automatic longint lane_sum(input logic [255:0] d);
    longint s = 0;
    for (int k = 0; k < 16; k++) s += longint'($signed(d[16*k +: 16]));
    return s;
  endfunction

  function automatic logic [255:0] fill(input logic [15:0] v);
    logic [255:0] r;
    for (int k = 0; k < 16; k++) r[16*k +: 16] = v;
    return r;
  endfunction

  function automatic logic [255:0] rand_vec();
    logic [255:0] r;
    for (int k = 0; k < 16; k++) r[16*k +: 16] = 16'($urandom);
    return r;
  endfunction

  // Handshakes are observed mid-cycle; they take effect at the next rising edge.
  always @(negedge clk) begin
    if (rst) begin
      m_acc32 = 0; m_acc20 = 0; m_ovf32 = 0; m_ovf20 = 0;
    end else begin
      if (in_valid && in_ready) begin
        m_beat = lane_sum(in_data);
        acc_step(m_acc32, m_ovf32, m_beat, 32);
        acc_step(m_acc20, m_ovf20, m_beat, 20);
        if (in_last) begin
          m_s.d32 = m_acc32[31:0];
          m_s.o32 = m_ovf32;
          m_s.d20 = m_acc20[19:0];
          m_s.o20 = m_ovf20;
          m_s.v20 = 1'b1;
          exp_q.push_back(m_s);
          m_acc32 = 0; m_acc20 = 0; m_ovf32 = 0; m_ovf20 = 0;
        end
      end
      if (out_valid && out_ready) begin
        m_s.d32 = out_data;
        m_s.o32 = out_ovf;
        m_s.d20 = out_data20;
        m_s.o20 = out_ovf20;
        m_s.v20 = out_valid20;
        got_q.push_back(m_s);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (no checking)
  // ---------------------------------------------------------------------------
  task automatic send_beat(input logic [255:0] d, input logic l);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(negedge clk);
    while (!in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      fails++;
      $display("FAIL send_timeout: in_ready stayed %b, required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    idle(8);
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b1;
    idle(3);
    checks++;
    if ({out_valid, out_ovf, out_data, in_ready} !== {1'b0, 1'b0, 32'd0, 1'b1}) begin
      fails++;
      $display("FAIL reset_w32: v/ovf/data/rdy = %b %b %h %b, required 0 0 0 1",
               out_valid, out_ovf, out_data, in_ready);
    end
    checks++;
    if ({out_valid20, out_ovf20, out_data20, in_ready20} !== {1'b0, 1'b0, 20'd0, 1'b1}) begin
      fails++;
      $display("FAIL reset_w20: v/ovf/data/rdy = %b %b %h %b, required 0 0 0 1",
               out_valid20, out_ovf20, out_data20, in_ready20);
    end
    rst = 1'b0;
    idle(1);
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_single();
    int n = 1;
    out_ready = 1'b1;
    send_beat(fill(16'd1), 1'b1);
    while (!out_valid && n < 10) begin
      idle(1);
      n++;
    end
    checks++;
    if (n != 3) begin
      fails++;
      $display("FAIL single_latency: %0d cycles, required 3", n);
    end
    checks++;
    if (out_data !== 32'd16 || out_ovf !== 1'b0) begin
      fails++;
      $display("FAIL single_value: data %0d ovf %b, required 16 0", $signed(out_data), out_ovf);
    end
    drain();
    checks++;
    if (got_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL single_count: %0d samples, required %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL single_sample[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_group();
    out_ready = 1'b1;
    for (int b = 0; b < 4; b++) send_beat(fill(16'hFFFE), b == 3);
    send_beat(fill(16'd3), 1'b1);
    drain();
    checks++;
    if (got_q.size() != 2) begin
      fails++;
      $display("FAIL group_count: %0d samples, required 2", got_q.size());
    end else begin
      checks++;
      if (got_q[0].d32 !== 32'hFFFF_FF80 || got_q[1].d32 !== 32'd48) begin
        fails++;
        $display("FAIL group_values: %0d then %0d, required -128 then 48",
                 $signed(got_q[0].d32), $signed(got_q[1].d32));
      end
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL group_sample[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_overflow();
    out_ready = 1'b1;
    for (int b = 0; b < 3; b++) send_beat(fill(16'h7FFF), b == 2);
    drain();
    checks++;
    if (got_q.size() != 1) begin
      fails++;
      $display("FAIL ovf_count: %0d samples, required 1", got_q.size());
    end else begin
      checks++;
      if (got_q[0].d20 !== 20'd524240 || got_q[0].o20 !== 1'b1) begin
        fails++;
        $display("FAIL ovf_w20: data %0d ovf %b, required 524240 1",
                 $signed(got_q[0].d20), got_q[0].o20);
      end
      checks++;
      if (got_q[0].d32 !== 32'd1572816 || got_q[0].o32 !== 1'b0) begin
        fails++;
        $display("FAIL ovf_w32: data %0d ovf %b, required 1572816 0",
                 $signed(got_q[0].d32), got_q[0].o32);
      end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_stall();
    logic [255:0] a, b, c;
    longint       a_sum, b_sum;
    a = rand_vec(); b = rand_vec(); c = rand_vec();
    a_sum = lane_sum(a);
    b_sum = lane_sum(b);
    out_ready = 1'b0;
    send_beat(a, 1'b1);
    send_beat(b, 1'b1);
    fork
      send_beat(c, 1'b1);
      begin
        idle(4);
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== a_sum[31:0]) begin
          fails++;
          $display("FAIL stall_hold: valid %b ready %b data %h, required 1 0 %h",
                   out_valid, in_ready, out_data, a_sum[31:0]);
        end
        out_ready = 1'b1;
        idle(1);
        checks++;
        if (out_valid !== 1'b1 || out_data !== b_sum[31:0]) begin
          fails++;
          $display("FAIL stall_release: valid %b data %h, required 1 %h",
                   out_valid, out_data, b_sum[31:0]);
        end
      end
    join
    drain();
    checks++;
    if (got_q.size() != 3 || exp_q.size() != 3) begin
      fails++;
      $display("FAIL stall_count: %0d samples, required 3", got_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL stall_sample[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_reset_mid();
    // Pending output sample discarded by reset.
    out_ready = 1'b0;
    send_beat(rand_vec(), 1'b1);
    idle(4);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'd0) begin
      fails++;
      $display("FAIL rst_stall: valid %b ready %b data %h, required 0 1 0",
               out_valid, in_ready, out_data);
    end
    exp_q.delete(); got_q.delete();
    // Partial group discarded by reset.
    out_ready = 1'b1;
    send_beat(fill(16'd9), 1'b0);
    send_beat(fill(16'd9), 1'b0);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    send_beat(fill(16'd5), 1'b1);
    drain();
    checks++;
    if (got_q.size() != 1) begin
      fails++;
      $display("FAIL rst_group_count: %0d samples, required 1", got_q.size());
    end else begin
      checks++;
      if (got_q[0].d32 !== 32'd80 || got_q[0].d20 !== 20'd80) begin
        fails++;
        $display("FAIL rst_group_value: %0d / %0d, required 80 / 80",
                 $signed(got_q[0].d32), $signed(got_q[0].d20));
      end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_toggle();
    logic [255:0] v;
    longint       sw = 0;
    out_ready = 1'b1;
    for (int b = 0; b < 5; b++) begin
      v = rand_vec();
      for (int k = 0; k < 16; k++) sw += longint'($signed(v[16*k +: 16]));
      send_beat(v, b == 4);
      idle(1);
    end
    drain();
    checks++;
    if (got_q.size() != 1) begin
      fails++;
      $display("FAIL toggle_count: %0d samples, required 1", got_q.size());
    end else begin
      checks++;
      if (got_q[0].d32 !== sw[31:0] || got_q[0].o32 !== 1'b0) begin
        fails++;
        $display("FAIL toggle_sum: %0d ovf %b, required %0d 0",
                 $signed(got_q[0].d32), got_q[0].o32, sw);
      end
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL toggle_sample[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_back_to_back();
    int  beats = 0;
    time t0;
    out_ready = 1'b1;
    t0 = $time;
    for (int g = 0; g < 10; g++) begin
      int len = $urandom_range(1, 6);
      for (int b = 0; b < len; b++) begin
        send_beat(rand_vec(), b == len - 1);
        beats++;
      end
    end
    checks++;
    if (($time - t0) != time'(beats * 10)) begin
      fails++;
      $display("FAIL b2b_rate: %0d beats took %0t, required %0d", beats, $time - t0, beats * 10);
    end
    drain();
    checks++;
    if (got_q.size() != 10 || exp_q.size() != 10) begin
      fails++;
      $display("FAIL b2b_count: %0d samples, required 10", got_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL b2b_sample[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_random_backpressure();
    bit done = 1'b0;
    fork
      begin
        for (int g = 0; g < 20; g++) begin
          int len = $urandom_range(1, 6);
          for (int b = 0; b < len; b++) begin
            send_beat(rand_vec(), b == len - 1);
            if ($urandom_range(0, 3) == 0) idle(1);
          end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          out_ready = 1'($urandom_range(0, 1));
          idle(1);
        end
      end
    join
    drain();
    checks++;
    if (got_q.size() != 20 || exp_q.size() != 20) begin
      fails++;
      $display("FAIL bp_count: %0d samples, required 20", got_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL bp_sample[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
    exp_q.delete(); got_q.delete();
  endtask

  initial begin
    test_reset();
    test_single();
    test_group();
    test_overflow();
    test_stall();
    test_reset_mid();
    test_toggle();
    test_back_to_back();
    test_random_backpressure();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
